// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
// Owner encoding for the in-flight response and the address legality check.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH_WORDS = 32768;
    localparam int DEF_STARVE_MAX  = 4;

    // Word aligned and the word index lands inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] w_idx;
        w_idx = {2'b00, addr[31:2]};
        return (addr[1:0] == 2'b00) && (w_idx < depth);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped as one bundle.
// slave = arbiter view, master = requesters plus memory array view.
interface imem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 15
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_err;

    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface

// File: rtl/imem_port_arbiter_starve_cnt.sv
// Counts consecutive cycles a pending DBG request was refused, saturating.
// force_dbg is registered state; it lets DBG jump ahead of IF for one grant.
module imem_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (dbg_req && !dbg_gnt) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign force_dbg = (r_cnt == CNT_MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous-read instruction memory port between fetch and debug.
// Grant is combinational; the response comes exactly one cycle after grant.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    logic        w_force_dbg;
    logic        w_if_gnt;
    logic        w_dbg_gnt;
    logic        w_any_gnt;
    logic [31:0] w_sel_addr;
    logic        w_addr_ok;
    logic        w_mem_en;

    owner_e      r_owner;
    logic        r_err;
    logic        r_we;
    owner_e      w_owner_nxt;
    logic        w_err_nxt;
    logic        w_we_nxt;

    logic        w_if_rvalid;
    logic        w_dbg_rvalid;

    imem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .dbg_req   (bus.dbg_req),
        .dbg_gnt   (w_dbg_gnt),
        .force_dbg (w_force_dbg)
    );

    // IF wins unless it is idle or DBG has been refused long enough.
    always_comb begin
        w_if_gnt  = 1'b0;
        w_dbg_gnt = 1'b0;
        if (!rst) begin
            if (bus.dbg_req && (!bus.if_req || w_force_dbg)) begin
                w_dbg_gnt = 1'b1;
            end else if (bus.if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt  = w_if_gnt || w_dbg_gnt;
    assign w_sel_addr = w_dbg_gnt ? bus.dbg_addr : bus.if_addr;
    assign w_addr_ok  = addr_ok(w_sel_addr, DEPTH_WORDS);
    assign w_mem_en   = w_any_gnt && w_addr_ok;

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dbg_gnt   = w_dbg_gnt;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_en && w_dbg_gnt && bus.dbg_we;
    assign bus.mem_idx   = w_mem_en ? w_sel_addr[IDX_W+1:2] : '0;
    assign bus.mem_wdata = w_mem_en ? bus.dbg_wdata : '0;

    always_comb begin
        w_owner_nxt = OWN_NONE;
        w_err_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        if (w_dbg_gnt) begin
            w_owner_nxt = OWN_DBG;
            w_err_nxt   = !w_addr_ok;
            w_we_nxt    = bus.dbg_we;
        end else if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
            w_err_nxt   = !w_addr_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_err   <= w_err_nxt;
            r_we    <= w_we_nxt;
        end
    end

    // Responses are squashed while rst is high so a grant just before reset is dropped.
    assign w_if_rvalid  = !rst && (r_owner == OWN_IF);
    assign w_dbg_rvalid = !rst && (r_owner == OWN_DBG);

    assign bus.if_rvalid  = w_if_rvalid;
    assign bus.if_err     = w_if_rvalid && r_err;
    assign bus.if_rdata   = (w_if_rvalid && !r_err) ? bus.mem_rdata : '0;

    assign bus.dbg_rvalid = w_dbg_rvalid;
    assign bus.dbg_err    = w_dbg_rvalid && r_err;
    assign bus.dbg_rdata  = (w_dbg_rvalid && !r_err && !r_we) ? bus.mem_rdata : '0;

    a_one_grant : assert property (@(posedge clk) !(w_if_gnt && w_dbg_gnt));
    a_we_needs_en : assert property (@(posedge clk) bus.mem_we |-> bus.mem_en);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomised bench for imem_port_arbiter with a transaction-level reference model.
// Directed sections pin the model with literal expectations.
module tb_imem_port_arbiter;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32768;
    localparam int IDX_W  = 15;
    localparam int SMAX   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    imem_port_arbiter #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .IDX_W       (IDX_W),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory array the arbiter drives.
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_idx];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h06140C93;
            1:       return 32'h01144313;
            2:       return 32'h40006193;
            default: return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
        endcase
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory plus one pending expected response.
    logic [31:0] shadow [int];
    int          m_starve = 0;
    int          m_owner  = 0;
    logic        m_err    = 1'b0;
    logic [31:0] m_data   = '0;

    function automatic logic [31:0] rd_shadow(input int idx);
        if (shadow.exists(idx)) return shadow[idx];
        return init_word(idx);
    endfunction

    always @(negedge clk) begin : p_model
        logic        e_ig, e_dg, e_ok, e_en, e_we;
        logic [31:0] e_addr, e_idx, e_wd;
        logic        e_irv, e_ierr, e_drv, e_derr;
        logic [31:0] e_ird, e_drd;
        if (rst) begin
            {e_ig, e_dg, e_en, e_we, e_irv, e_ierr, e_drv, e_derr} = '0;
            e_idx = '0; e_wd = '0; e_ird = '0; e_drd = '0;
            m_starve = 0; m_owner = 0; m_err = 1'b0; m_data = '0;
        end else begin
            e_irv  = (m_owner == 1);
            e_ierr = e_irv && m_err;
            e_ird  = e_irv ? m_data : 32'h0;
            e_drv  = (m_owner == 2);
            e_derr = e_drv && m_err;
            e_drd  = e_drv ? m_data : 32'h0;

            e_dg   = bus.dbg_req && (!bus.if_req || m_starve == SMAX);
            e_ig   = bus.if_req && !e_dg;
            e_addr = e_dg ? bus.dbg_addr : bus.if_addr;
            e_ok   = (e_addr % 4 == 0) && (e_addr / 4 < DEPTH);
            e_en   = (e_ig || e_dg) && e_ok;
            e_we   = e_en && e_dg && bus.dbg_we;
            e_idx  = e_en ? e_addr / 4 : 32'h0;
            e_wd   = e_en ? bus.dbg_wdata : 32'h0;

            m_owner = e_dg ? 2 : (e_ig ? 1 : 0);
            m_err   = !e_ok;
            m_data  = (!e_ok || (e_dg && bus.dbg_we)) ? 32'h0 : rd_shadow(int'(e_addr / 4));
            if (e_we) shadow[int'(e_idx)] = bus.dbg_wdata;
            m_starve = (bus.dbg_req && !e_dg) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end
        chk("if_gnt",     bus.if_gnt,     e_ig);
        chk("dbg_gnt",    bus.dbg_gnt,    e_dg);
        chk("mem_en",     bus.mem_en,     e_en);
        chk("mem_we",     bus.mem_we,     e_we);
        chk("mem_idx",    bus.mem_idx,    e_idx);
        chk("mem_wdata",  bus.mem_wdata,  e_wd);
        chk("if_rvalid",  bus.if_rvalid,  e_irv);
        chk("if_err",     bus.if_err,     e_ierr);
        chk("if_rdata",   bus.if_rdata,   e_ird);
        chk("dbg_rvalid", bus.dbg_rvalid, e_drv);
        chk("dbg_err",    bus.dbg_err,    e_derr);
        chk("dbg_rdata",  bus.dbg_rdata,  e_drd);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic req, input logic [31:0] addr);
        bus.if_req  = req;
        bus.if_addr = addr;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wd;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return $urandom;
            1:       return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            2:       return 32'h0002_0000 + 32'(4 * $urandom_range(0, 3));
            3:       return 32'((DEPTH - 1) * 4);
            default: return 32'(4 * $urandom_range(0, 63));
        endcase
    endfunction

    logic ig_prev, dg_prev;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
        rst = 1'b1;
        set_if(1'b0, '0);
        set_dbg(1'b0, 1'b0, '0, '0);
        repeat (3) cyc();

        // Consecutive fetches of preloaded words.
        rst = 1'b0;
        set_if(1'b1, 32'h0);
        #5 chk("d_if_gnt0", bus.if_gnt, 1'b1);
        cyc(); set_if(1'b1, 32'h4);
        #5 chk("d_if_rd0", bus.if_rdata, 32'h06140C93);
        cyc(); set_if(1'b1, 32'h8);
        #5 chk("d_if_rd1", bus.if_rdata, 32'h01144313);
        cyc(); set_if(1'b0, 32'h0);
        #5 chk("d_if_rd2", bus.if_rdata, 32'h40006193);
        chk("d_if_err2", bus.if_err, 1'b0);

        // DBG write then read back.
        cyc(); set_dbg(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #5 chk("d_wr_idx", bus.mem_idx, 32'd4);
        cyc(); set_dbg(1'b1, 1'b0, 32'h10, 32'h0);
        #5 chk("d_wr_ack", bus.dbg_rvalid, 1'b1);
        chk("d_wr_rdata", bus.dbg_rdata, 32'h0);
        cyc(); set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #5 chk("d_rd_back", bus.dbg_rdata, 32'hDEADBEEF);

        // Misaligned fetch and out-of-range write.
        cyc(); set_if(1'b1, 32'h6);
        #5 chk("d_mis_en", bus.mem_en, 1'b0);
        cyc(); set_if(1'b0, 32'h0);
        #5 chk("d_mis_err", bus.if_err, 1'b1);
        cyc(); set_dbg(1'b1, 1'b1, 32'h0002_0000, 32'hFFFFFFFF);
        #5 chk("d_oor_en", bus.mem_en, 1'b0);
        cyc(); set_dbg(1'b1, 1'b0, 32'h0, 32'h0);
        #5 chk("d_oor_err", bus.dbg_err, 1'b1);
        cyc(); set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #5 chk("d_word0_kept", bus.dbg_rdata, 32'h06140C93);

        // Both requesters held: IF x4 then DBG.
        cyc(); set_if(1'b1, 32'h40); set_dbg(1'b1, 1'b0, 32'h44, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #5 chk("d_starve_if", bus.if_gnt, (i % 5) != 4);
            chk("d_starve_dbg", bus.dbg_gnt, (i % 5) == 4);
            cyc();
        end
        set_if(1'b0, 32'h0); set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();

        // Reset right after an IF grant drops the response and clears the starve count.
        set_if(1'b1, 32'h0); set_dbg(1'b1, 1'b0, 32'h10, 32'h0);
        #5 chk("d_pre_rst_gnt", bus.if_gnt, 1'b1);
        cyc(); rst = 1'b1;
        #5 chk("d_rst_rvalid", bus.if_rvalid, 1'b0);
        chk("d_rst_gnt", bus.dbg_gnt, 1'b0);
        cyc();
        #5 chk("d_rst2_rvalid", bus.if_rvalid, 1'b0);
        cyc(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #5 chk("d_post_rst_if", bus.if_gnt, i != 4);
            cyc();
        end
        set_if(1'b0, 32'h0);
        #5 chk("d_post_rst_dbg", bus.dbg_gnt, 1'b1);
        cyc(); set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #5 chk("d_post_rst_rd", bus.dbg_rdata, 32'hDEADBEEF);
        cyc();

        // Random traffic; requesters hold until granted.
        ig_prev = 1'b0; dg_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.if_req || ig_prev)
                set_if($urandom_range(0, 3) != 0, rand_addr());
            if (!bus.dbg_req || dg_prev)
                set_dbg($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            rst = ($urandom_range(0, 299) == 0);
            #5;
            ig_prev = bus.if_gnt;
            dg_prev = bus.dbg_gnt;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
